// File: rtl/uart_cmd_parser.sv
// ============================================================================
// uart_cmd_parser -- parses 8-byte pulse-command frames from a UART receiver
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
  parameter logic [25:0] CLK_FREQ    = 26'd50_000_000,
  parameter logic [13:0] UART_BPS    = 14'd9600,
  parameter logic [7:0]  HEADER      = 8'h07,
  parameter int unsigned TIMEOUT_CYC = (CLK_FREQ / UART_BPS) * 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       pulse_en1,
  output logic       pulse_en2,
  output logic [7:0] width1,
  output logic [7:0] width2,
  output logic [7:0] interval,
  output logic       cfg_valid,
  output logic       frame_err,
  output logic [7:0] ack_data,
  output logic       ack_flag
);

  localparam int unsigned GAP_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  // Timeout fires on the edge where the count would reach TIMEOUT_CYC
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] ACK_OK  = 8'hA5;
  localparam logic [7:0] ACK_BAD = 8'hEE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       byte_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       frame_buf [8];
  logic [7:0]       frame_xor;

  // XOR over all eight bytes is zero exactly when B7 equals XOR of B0..B6
  always_comb begin
    frame_xor = 8'h00;
    for (int i = 0; i < 8; i++) begin
      frame_xor = frame_xor ^ frame_buf[i];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      byte_idx  <= 3'd0;
      gap_cnt   <= '0;
      for (int i = 0; i < 8; i++) begin
        frame_buf[i] <= 8'h00;
      end
      pulse_en1 <= 1'b0;
      pulse_en2 <= 1'b0;
      width1    <= 8'h00;
      width2    <= 8'h00;
      interval  <= 8'h00;
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      ack_data  <= 8'h00;
      ack_flag  <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      ack_flag  <= 1'b0;

      case (state)
        S_IDLE: begin
          gap_cnt <= '0;
          if (pi_flag && (pi_data == HEADER)) begin
            frame_buf[0] <= pi_data;
            byte_idx     <= 3'd1;
            state        <= S_RECV;
          end
        end

        S_RECV: begin
          if (pi_flag) begin
            frame_buf[byte_idx] <= pi_data;
            byte_idx            <= byte_idx + 3'd1;
            gap_cnt             <= '0;
            if (byte_idx == 3'd7) begin
              state <= S_CHECK;
            end
          end else if (gap_cnt == GAP_LAST) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
            byte_idx  <= 3'd0;
            gap_cnt   <= '0;
            for (int i = 0; i < 8; i++) begin
              frame_buf[i] <= 8'h00;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          state    <= S_IDLE;
          byte_idx <= 3'd0;
          ack_flag <= 1'b1;
          if (frame_xor == 8'h00) begin
            pulse_en1 <= frame_buf[1][0];
            pulse_en2 <= frame_buf[2][0];
            width1    <= frame_buf[3];
            width2    <= frame_buf[4];
            interval  <= frame_buf[5];
            cfg_valid <= 1'b1;
            ack_data  <= ACK_OK;
          end else begin
            frame_err <= 1'b1;
            ack_data  <= ACK_BAD;
          end
        end

        default: begin
          state    <= S_IDLE;
          byte_idx <= 3'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// tb_uart_cmd_parser -- scoreboard bench for uart_cmd_parser
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

  localparam int unsigned TMO = 64;
  localparam logic [7:0]  HDR = 8'h07;

  logic       clk;
  logic       rst_n;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       pulse_en1, pulse_en2, cfg_valid, frame_err, ack_flag;
  logic [7:0] width1, width2, interval, ack_data;

  uart_cmd_parser #(
    .CLK_FREQ   (26'd1_000_000),
    .UART_BPS   (14'd9600),
    .HEADER     (HDR),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .pi_data  (pi_data),
    .pi_flag  (pi_flag),
    .pulse_en1(pulse_en1),
    .pulse_en2(pulse_en2),
    .width1   (width1),
    .width2   (width2),
    .interval (interval),
    .cfg_valid(cfg_valid),
    .frame_err(frame_err),
    .ack_data (ack_data),
    .ack_flag (ack_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        cfg;
    logic        err;
    logic        ack;
    logic [7:0]  ackd;
    logic        e1;
    logic        e2;
    logic [7:0]  w1;
    logic [7:0]  w2;
    logic [7:0]  iv;
    logic [31:0] at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_issue = 0;

  // reference configuration state
  logic       m_e1 = 1'b0, m_e2 = 1'b0;
  logic [7:0] m_w1 = 8'h00, m_w2 = 8'h00, m_iv = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe cycle must match the next expected event
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (cfg_valid || frame_err || ack_flag)) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {29'd0, cfg_valid, frame_err, ack_flag}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("latency",   cyc, e.at);
        chk("cfg_valid", {31'd0, cfg_valid}, {31'd0, e.cfg});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.err});
        chk("ack_flag",  {31'd0, ack_flag},  {31'd0, e.ack});
        if (e.ack) chk("ack_data", {24'd0, ack_data}, {24'd0, e.ackd});
        chk("pulse_en1", {31'd0, pulse_en1}, {31'd0, e.e1});
        chk("pulse_en2", {31'd0, pulse_en2}, {31'd0, e.e2});
        chk("width1",    {24'd0, width1},    {24'd0, e.w1});
        chk("width2",    {24'd0, width2},    {24'd0, e.w2});
        chk("interval",  {24'd0, interval},  {24'd0, e.iv});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the byte is sampled on the next edge
  task automatic send_byte(input logic [7:0] d);
    pi_data    = d;
    pi_flag    = 1'b1;
    last_issue = cyc;
    @(posedge clk);
    #1;
    pi_flag = 1'b0;
  endtask

  task automatic push_event(input logic cfg, input logic err, input logic ack,
                            input logic [7:0] ackd, input int at);
    exp_t e;
    e = '{cfg: cfg, err: err, ack: ack, ackd: ackd, e1: m_e1, e2: m_e2,
          w1: m_w1, w2: m_w2, iv: m_iv, at: at};
    q.push_back(e);
  endtask

  // f[63:56] is B0; tail=1 sends an extra header byte that lands in CHECK
  task automatic send_frame(input logic [63:0] f, input bit tail);
    logic [7:0] b [8];
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b[i] = f[63-8*i -: 8];
      if (i < 7) x = x ^ b[i];
      send_byte(b[i]);
    end
    if (b[7] == x) begin
      m_e1 = b[1][0]; m_e2 = b[2][0];
      m_w1 = b[3]; m_w2 = b[4]; m_iv = b[5];
      push_event(1'b1, 1'b0, 1'b1, 8'hA5, last_issue + 2);
    end else begin
      push_event(1'b0, 1'b1, 1'b1, 8'hEE, last_issue + 2);
    end
    if (tail) send_byte(HDR);
    idle(3);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_en1"},  {31'd0, pulse_en1}, 32'd0);
    chk({tag, "_en2"},  {31'd0, pulse_en2}, 32'd0);
    chk({tag, "_w1"},   {24'd0, width1},    32'd0);
    chk({tag, "_w2"},   {24'd0, width2},    32'd0);
    chk({tag, "_iv"},   {24'd0, interval},  32'd0);
    chk({tag, "_strb"}, {29'd0, cfg_valid, frame_err, ack_flag}, 32'd0);
    chk({tag, "_ackd"}, {24'd0, ack_data},  32'd0);
  endtask

  localparam logic [63:0] F_V1   = 64'h07_01_01_0A_14_32_00_2B;
  localparam logic [63:0] F_V2   = 64'h07_01_01_0A_14_32_00_2C;
  localparam logic [63:0] F_V6   = 64'h07_02_03_FF_00_01_7E_86;
  localparam logic [63:0] F_HDAT = 64'h07_01_07_07_07_07_07_01;

  initial begin
    rst_n   = 1'b0;
    pi_flag = 1'b0;
    pi_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    send_frame(F_V1, 1'b0);                 // V-1
    send_frame(F_V2, 1'b0);                 // V-2: bad checksum, config held
    send_byte(8'h55); idle(2);              // V-3: noise ignored
    send_byte(8'hAA); idle(2);
    send_frame(F_V1, 1'b0);
    send_frame(F_V6, 1'b0);                 // V-6

    // V-4: timeout after three bytes
    send_byte(HDR); send_byte(8'h01); send_byte(8'h01);
    push_event(1'b0, 1'b1, 1'b0, 8'h00, last_issue + 1 + TMO);
    idle(TMO + 10);
    send_frame(F_V1, 1'b0);

    send_frame(F_HDAT, 1'b0);               // header values as data
    send_frame(F_V6, 1'b1);                 // byte during CHECK dropped
    send_frame(F_V1, 1'b0);

    // V-5: reset mid-frame
    send_byte(HDR); send_byte(8'h01); send_byte(8'h01); send_byte(8'h0A);
    #2 rst_n = 1'b0;
    #1;
    m_e1 = 1'b0; m_e2 = 1'b0; m_w1 = 8'h00; m_w2 = 8'h00; m_iv = 8'h00;
    check_zero_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    send_frame(F_V1, 1'b0);

    idle(10);
    chk("pending_events", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
